// File: rtl/branch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pkg
//  Description : Shared types and default constants for the branch flush
//                controller and its oldest-first arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package branch_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        REDIRECT = 2'd2
    } bfc_state_t;

    // Default configuration
    localparam int unsigned c_NUM_BR_DEFAULT       = 4;
    localparam int unsigned c_PC_W_DEFAULT         = 32;
    localparam int unsigned c_FLUSH_CYCLES_DEFAULT = 2;

endpackage : branch_pkg
`default_nettype wire

// File: rtl/oldest_first_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : oldest_first_arbiter
//  Description : Combinational rotating-priority picker. Slot head_ptr has the
//                highest priority, then head_ptr+1, ... wrapping modulo
//                NUM_BR, so the grant is the requesting slot of smallest age.
//  Revision    : 1.0 - initial release
// ============================================================================
module oldest_first_arbiter
    import branch_pkg::*;
#(
    parameter int unsigned NUM_BR = c_NUM_BR_DEFAULT,
    parameter int unsigned IDX_W  = $clog2(NUM_BR)
) (
    input  logic [NUM_BR-1:0] i_req,
    input  logic [IDX_W-1:0]  i_head_ptr,
    output logic [IDX_W-1:0]  o_grant,
    output logic              o_any_grant
);

    logic [IDX_W-1:0] w_idx;

    // Scan from youngest to oldest so the last hit (oldest) overrides.
    // Index arithmetic wraps naturally because NUM_BR is a power of two.
    always_comb begin
        o_grant     = '0;
        o_any_grant = 1'b0;
        w_idx       = '0;
        for (int k = NUM_BR - 1; k >= 0; k--) begin
            w_idx = i_head_ptr + IDX_W'(k);
            if (i_req[w_idx]) begin
                o_grant     = w_idx;
                o_any_grant = 1'b1;
            end
        end
    end

endmodule : oldest_first_arbiter
`default_nettype wire

// File: rtl/branch_flush_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_flush_ctrl
//  Description : Picks the oldest valid mispredicted branch among NUM_BR
//                resolved slots, holds flush for FLUSH_CYCLES cycles, then
//                offers a valid/ready redirect to fetch.
//                Optional macro BRANCH_FLUSH_STATS_EN adds a saturating
//                32-bit flush_count output.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_flush_ctrl
    import branch_pkg::*;
#(
    parameter int unsigned NUM_BR       = c_NUM_BR_DEFAULT,
    parameter int unsigned PC_W         = c_PC_W_DEFAULT,
    parameter int unsigned FLUSH_CYCLES = c_FLUSH_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_BR-1:0]        br_valid,
    input  logic [NUM_BR-1:0]        br_mispred,
    input  logic [NUM_BR*PC_W-1:0]   br_target,
    input  logic [$clog2(NUM_BR)-1:0] head_ptr,
    input  logic                     redirect_ready,
    output logic                     flush,
    output logic [$clog2(NUM_BR)-1:0] flush_slot,
    output logic                     redirect_valid,
    output logic [PC_W-1:0]          redirect_pc,
    output logic                     busy
`ifdef BRANCH_FLUSH_STATS_EN
    ,
    output logic [31:0]              flush_count
`endif
);

    localparam int unsigned c_IDX_W = $clog2(NUM_BR);
    localparam int unsigned c_CNT_W = $clog2(FLUSH_CYCLES + 1);

    localparam logic [1:0] c_ST_IDLE     = IDLE;
    localparam logic [1:0] c_ST_FLUSH    = FLUSH;
    localparam logic [1:0] c_ST_REDIRECT = REDIRECT;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_flush_slot;
    logic [PC_W-1:0]    r_redirect_pc;

    logic [NUM_BR-1:0]  w_cand;
    logic [c_IDX_W-1:0] w_grant;
    logic               w_any;
    logic               w_start;

    assign w_cand  = br_valid & br_mispred;
    assign w_start = (r_state == c_ST_IDLE) && w_any;

    oldest_first_arbiter #(
        .NUM_BR (NUM_BR),
        .IDX_W  (c_IDX_W)
    ) u_arb (
        .i_req       (w_cand),
        .i_head_ptr  (head_ptr),
        .o_grant     (w_grant),
        .o_any_grant (w_any)
    );

    // Flush/redirect sequencer; branch inputs only matter while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_cnt         <= '0;
            r_flush_slot  <= '0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_any) begin
                        r_flush_slot  <= w_grant;
                        r_redirect_pc <= br_target[w_grant*PC_W +: PC_W];
                        r_cnt         <= c_CNT_W'(FLUSH_CYCLES - 1);
                        r_state       <= c_ST_FLUSH;
                    end
                end
                c_ST_FLUSH: begin
                    // Leaving at zero means the counter never underflows.
                    if (r_cnt == '0) begin
                        r_state <= c_ST_REDIRECT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decodes of registered state only.
    assign flush          = (r_state == c_ST_FLUSH);
    assign redirect_valid = (r_state == c_ST_REDIRECT);
    assign busy           = (r_state != c_ST_IDLE);
    assign flush_slot     = r_flush_slot;
    assign redirect_pc    = r_redirect_pc;

`ifdef BRANCH_FLUSH_STATS_EN
    logic [31:0] r_flush_count;

    // Saturating count of flush sequences started.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_count <= '0;
        end else if (w_start && (r_flush_count != '1)) begin
            r_flush_count <= r_flush_count + 32'd1;
        end
    end

    assign flush_count = r_flush_count;
`else
    logic w_unused_start;
    assign w_unused_start = w_start;
`endif

endmodule : branch_flush_ctrl
`default_nettype wire

// File: doc/branch_flush_ctrl.md
# branch_flush_ctrl

Registered, parametrised branch-resolution flush controller for the superscalar back end. Each cycle it examines up to NUM_BR resolved branches and selects the oldest valid mispredict, using a rotating head pointer rather than fixed slot order. It then drives a multi-cycle pipeline flush followed by a valid/ready redirect to fetch. It sits between the branch execution units and the fetch/rename flush network.

## Interface
- NUM_BR, 4: branch slots resolved per cycle; power of two, ≥2.
- PC_W, 32: redirect target width.
- FLUSH_CYCLES, 2: cycles `flush` is held; ≥1.
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- br_valid  in  NUM_BR  slot i holds a resolved branch.
- br_mispred  in  NUM_BR  slot i resolved as mispredicted; ignored unless br_valid[i].
- br_target  in  NUM_BR×PC_W  correct target for slot i.
- head_ptr  in  log2(NUM_BR)  index of the oldest slot this cycle.
- redirect_ready  in  1  fetch accepts the redirect.
- flush  out  1  pipeline flush.
- flush_slot  out  log2(NUM_BR)  slot that caused the current flush.
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  PC_W  corrected fetch PC.
- busy  out  1  high in any state other than IDLE; upstream must not present new resolutions while it is high.

## Operation
- Age of slot i = (i − head_ptr) mod NUM_BR; age 0 is the oldest.
- Candidate set = br_valid & br_mispred. The winner is the candidate with the smallest age. No candidates means no action. A fixed default slot is never flushed.
- FSM states: IDLE, FLUSH, REDIRECT.
- IDLE: with at least one candidate, latch winner index → flush_slot and br_target[winner] → redirect_pc, load cnt = FLUSH_CYCLES−1, go to FLUSH. Otherwise stay in IDLE.
- FLUSH: flush = 1. If cnt == 0, go to REDIRECT; else decrement cnt. Branch inputs are ignored.
- REDIRECT: redirect_valid = 1, redirect_pc stable. On redirect_valid & redirect_ready, go to IDLE. Otherwise hold all outputs. Branch inputs are ignored.
- Reset values: state = IDLE, flush = 0, redirect_valid = 0, flush_slot = 0, redirect_pc = 0, cnt = 0, busy = 0.
- rst asserted in any state returns to IDLE at the next edge and clears everything. An in-flight redirect is dropped.
- Counter width is $clog2(FLUSH_CYCLES+1). No underflow, because exit from FLUSH happens at cnt == 0.

## Timing
- Mispredict presented at edge t:
  - flush is high for cycles t+1 … t+FLUSH_CYCLES.
  - redirect_valid rises at t+FLUSH_CYCLES+1.
- Minimum turnaround: handshake completes at edge r, state is IDLE at r+1, and a new mispredict can be sampled at edge r+1.
- flush and redirect_valid are never high in the same cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- BRANCH_FLUSH_STATS_EN defined: adds output `flush_count` (32 bits). It increments on each IDLE→FLUSH transition, saturates at all-ones, and clears on rst.
- Macro undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `branch_pkg`:
  - state enum `bfc_state_t` {IDLE, FLUSH, REDIRECT}.
  - default constants for NUM_BR, PC_W and FLUSH_CYCLES.
- Sub-module `oldest_first_arbiter`: combinational rotating-priority picker.
  - Inputs: request vector, head_ptr.
  - Outputs: grant index, any_grant.
  - Instantiated once. The FSM and registers stay in the top module.

## Test plan
- Single mispredict (NUM_BR=4, FLUSH_CYCLES=2, head_ptr=0): slot 2 valid+mispred with target 0x1000 at edge t → flush high at t+1 and t+2, flush_slot=2; redirect_valid at t+3 with redirect_pc=0x1000; redirect_ready=1 → IDLE at t+4.
- Age wrap-around: head_ptr=3, mispredicts in slots 1 and 3 → slot 3 wins (age 0); repeat with head_ptr=2 → slot 3 wins over slot 1.
- No mispredict: all br_valid=1, br_mispred=0 for 10 cycles → flush, redirect_valid and busy stay 0.
- Redirect backpressure: hold redirect_ready=0 for 5 cycles in REDIRECT while driving new mispredicts → redirect_pc unchanged, no re-flush; ready=1 → IDLE next cycle.
- Reset mid-flush: assert rst during the second flush cycle → next cycle every output is at its reset value; the next mispredict after reset follows the normal timing.
- Stats (BRANCH_FLUSH_STATS_EN defined): 3 back-to-back flush sequences → flush_count=3; rst → 0.
